// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - BCD hh:mm:ss countdown timer with expiry flag
//
// Counts a loaded BCD duration down to 00:00:00 by one second per ena tick,
// then flags expiry. With AUTO_RELOAD=1 the last accepted duration is
// reloaded on expiry and counting continues.
//
// Ports:
//   clk       in   1  clock, all logic on posedge
//   reset     in   1  synchronous, active-high
//   ena       in   1  one-second count tick
//   load      in   1  capture ld_hh/ld_mm/ld_ss (validated)
//   ld_hh     in   8  BCD hours 00-99
//   ld_mm     in   8  BCD minutes 00-59
//   ld_ss     in   8  BCD seconds 00-59
//   start     in   1  begin/resume counting
//   stop      in   1  pause counting
//   hh        out  8  current BCD hours
//   mm        out  8  current BCD minutes
//   ss        out  8  current BCD seconds
//   running   out  1  high while counting
//   expired   out  1  one-cycle pulse on reaching zero
//   load_err  out  1  one-cycle pulse after a rejected load

module bcd_countdown_timer #(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       load,
    input  logic [7:0] ld_hh,
    input  logic [7:0] ld_mm,
    input  logic [7:0] ld_ss,
    input  logic       start,
    input  logic       stop,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       running,
    output logic       expired,
    output logic       load_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [23:0] count, count_nxt;
    logic [23:0] reload_val, reload_nxt;
    logic        expired_nxt;
    logic        load_err_nxt;
    logic        ld_valid;
    logic [23:0] count_dec;

    // Subtract one second from a packed {hh,mm,ss} BCD value. Digit 0 is the
    // seconds ones digit; digits 1 and 3 are the tens of seconds/minutes and
    // wrap to 5 on borrow, all others wrap to 9. Only called with a nonzero
    // count, so the borrow never runs off the top of the hours.
    function automatic logic [23:0] bcd_dec(input logic [23:0] t);
        logic [23:0] r;
        logic [3:0]  dig;
        logic        borrow;
        r      = t;
        borrow = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dig = t[i*4 +: 4];
            if (borrow) begin
                if (dig == 4'd0) begin
                    dig = (i == 1 || i == 3) ? 4'd5 : 4'd9;
                end else begin
                    dig    = dig - 4'd1;
                    borrow = 1'b0;
                end
            end
            r[i*4 +: 4] = dig;
        end
        return r;
    endfunction

    assign ld_valid = (ld_hh[7:4] <= 4'd9) && (ld_hh[3:0] <= 4'd9) &&
                      (ld_mm[7:4] <= 4'd5) && (ld_mm[3:0] <= 4'd9) &&
                      (ld_ss[7:4] <= 4'd5) && (ld_ss[3:0] <= 4'd9);

    assign count_dec = bcd_dec(count);

    // Strict priority: only the highest asserted strobe acts in a cycle.
    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        reload_nxt   = reload_val;
        expired_nxt  = 1'b0;
        load_err_nxt = 1'b0;

        if (load) begin
            if (ld_valid) begin
                count_nxt  = {ld_hh, ld_mm, ld_ss};
                reload_nxt = {ld_hh, ld_mm, ld_ss};
                state_nxt  = IDLE;
            end else begin
                load_err_nxt = 1'b1;
            end
        end else if (stop) begin
            if (state == RUN) begin
                state_nxt = PAUSE;
            end
        end else if (start) begin
            if (state == IDLE || state == PAUSE) begin
                if (count != 24'h0) begin
                    state_nxt = RUN;
                end else begin
                    // Starting an empty timer expires immediately. Suppressing
                    // the pulse when it is already high keeps expired from
                    // ever being asserted on two consecutive cycles.
                    expired_nxt = ~expired;
                    state_nxt   = AUTO_RELOAD ? IDLE : DONE;
                end
            end
        end else if (ena && state == RUN) begin
            if (count == 24'h00_00_01) begin
                expired_nxt = ~expired;
                if (AUTO_RELOAD) begin
                    count_nxt = reload_val;
                end else begin
                    count_nxt = 24'h0;
                    state_nxt = DONE;
                end
            end else begin
                count_nxt = count_dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= 24'h0;
            reload_val <= 24'h0;
            expired    <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            reload_val <= reload_nxt;
            expired    <= expired_nxt;
            load_err   <= load_err_nxt;
        end
    end

    assign hh      = count[23:16];
    assign mm      = count[15:8];
    assign ss      = count[7:0];
    assign running = (state == RUN);

endmodule
